// File: rtl/cabin_light_fader_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : cabin_light_pkg                                            |
// | Purpose  : Shared sizes and types for the cabin light fader.          |
// |            NUM_CH - channel count (tied to the 2-bit mux select)      |
// |            DUTY_W - duty value width (matches pwm_generator input)    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package cabin_light_pkg;

  localparam int NUM_CH = 4;
  localparam int DUTY_W = 4;

  typedef logic [1:0]        ch_idx_t;
  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } fader_state_t;

endpackage
`default_nettype wire

// File: rtl/cabin_light_fader_tick_strobe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tick_strobe                                                |
// | Purpose  : Free-running mod-DIV counter emitting a one-clock pulse    |
// |            while the count sits at DIV-1.                             |
// | Ports    : clk     in  system clock                                   |
// |            rst_n   in  asynchronous active-low reset                  |
// |            o_tick  out strobe, high one clock in every DIV            |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tick_strobe #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  // A 1-bit counter is kept for DIV=1 so the vector is never zero-width;
  // the count then never leaves 0 and the strobe is permanently high.
  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cabin_light_fader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : cabin_light_fader                                          |
// | Purpose  : Accepts per-channel brightness commands over valid/ready   |
// |            and ramps four duty values toward their targets, one step  |
// |            per fade tick. Also drives the LED mux scan select.        |
// | Ports    : clk            in   system clock                           |
// |            rst_n          in   asynchronous active-low reset          |
// |            i_cmd_valid    in   command present                        |
// |            o_cmd_ready    out  command can be accepted                |
// |            i_cmd_ch       in   target channel index                   |
// |            i_cmd_target   in   target duty value                      |
// |            i_cmd_instant  in   1 = jump to target, 0 = fade           |
// |            o_duty_flat    out  channel i duty at [4i+3:4i]            |
// |            o_sel          out  scan select for led_mux                |
// |            o_busy         out  per-channel duty != target             |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module cabin_light_fader
  import cabin_light_pkg::*;
#(
  parameter int TICK_DIV = 1024,
  parameter int SCAN_DIV = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [1:0]               i_cmd_ch,
  input  logic [DUTY_W-1:0]        i_cmd_target,
  input  logic                     i_cmd_instant,
  output logic [NUM_CH*DUTY_W-1:0] o_duty_flat,
  output logic [1:0]               o_sel,
  output logic [NUM_CH-1:0]        o_busy
);

  fader_state_t r_state;
  fader_state_t w_state_nxt;
  logic         w_accept;
  logic         w_apply;

  ch_idx_t r_stg_ch;
  duty_t   r_stg_tgt;
  logic    r_stg_inst;

  duty_t r_duty     [NUM_CH];
  duty_t r_tgt      [NUM_CH];
  duty_t w_duty_nxt [NUM_CH];
  duty_t w_tgt_nxt  [NUM_CH];

  logic       w_fade_tick;
  logic       w_scan_tick;
  logic [1:0] r_sel;

  tick_strobe #(.DIV(TICK_DIV)) u_fade_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_fade_tick)
  );

  tick_strobe #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_scan_tick)
  );

  // Command FSM: IDLE accepts, APPLY commits the staged command.
  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_state_nxt = APPLY;
        end
      end
      APPLY: begin
        w_apply     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_accept = i_cmd_valid & o_cmd_ready;

  // Per-channel next values. The channel being written in APPLY is frozen
  // for a coincident fade tick so the new target/duty takes effect cleanly.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic w_hit;
      logic w_up;
      logic w_step;

      assign w_hit  = w_apply && (r_stg_ch == ch_idx_t'(i));
      assign w_up   = (r_tgt[i] > r_duty[i]);
      assign w_step = w_fade_tick && !w_hit && o_busy[i];

      assign w_duty_nxt[i] = (w_hit && r_stg_inst) ? r_stg_tgt :
                             w_step ? (w_up ? r_duty[i] + duty_t'(1)
                                            : r_duty[i] - duty_t'(1)) :
                             r_duty[i];
      assign w_tgt_nxt[i]  = w_hit ? r_stg_tgt : r_tgt[i];

      assign o_busy[i]                     = (r_duty[i] != r_tgt[i]);
      assign o_duty_flat[DUTY_W*i +: DUTY_W] = r_duty[i];
    end
  endgenerate

  assign o_sel = r_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_stg_ch   <= '0;
      r_stg_tgt  <= '0;
      r_stg_inst <= 1'b0;
      r_sel      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty[i] <= '0;
        r_tgt[i]  <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_stg_ch   <= i_cmd_ch;
        r_stg_tgt  <= i_cmd_target;
        r_stg_inst <= i_cmd_instant;
      end
      if (w_scan_tick) begin
        r_sel <= r_sel + 2'd1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty[i] <= w_duty_nxt[i];
        r_tgt[i]  <= w_tgt_nxt[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cabin_light_fader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_cabin_light_fader                                       |
// | Purpose  : Self-checking bench for cabin_light_fader. A cycle-level   |
// |            behavioural model (integer duties/targets, edge counter)   |
// |            is compared with the DUT every cycle, plus directed        |
// |            literal checks and a randomized command phase.             |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_cabin_light_fader;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_ch = '0;
  logic [3:0]  i_cmd_target = '0;
  logic        i_cmd_instant = 1'b0;
  logic [15:0] o_duty_flat;
  logic [1:0]  o_sel;
  logic [3:0]  o_busy;

  int total = 0;
  int bad   = 0;

  cabin_light_fader #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_ch      (i_cmd_ch),
    .i_cmd_target  (i_cmd_target),
    .i_cmd_instant (i_cmd_instant),
    .o_duty_flat   (o_duty_flat),
    .o_sel         (o_sel),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_duty [4];
  int m_tgt  [4];
  bit m_pend;
  int m_pch, m_pt;
  bit m_pi;
  int ecnt;          // clock edges since reset release
  int acc_q [$];     // edge index of every accepted command

  initial begin : model
    int od [4];
    int ot [4];
    bit tick;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) begin m_duty[i] = 0; m_tgt[i] = 0; end
        m_pend = 0; m_pch = 0; m_pt = 0; m_pi = 0; ecnt = 0;
      end else begin
        tick = ((ecnt % TICK_DIV) == TICK_DIV - 1);
        for (int i = 0; i < 4; i++) begin od[i] = m_duty[i]; ot[i] = m_tgt[i]; end
        for (int i = 0; i < 4; i++) begin
          if (tick && !(m_pend && m_pch == i) && od[i] != ot[i])
            m_duty[i] = od[i] + ((ot[i] > od[i]) ? 1 : -1);
        end
        if (m_pend) begin
          m_tgt[m_pch] = m_pt;
          if (m_pi) m_duty[m_pch] = m_pt;
          m_pend = 0;
        end else if (i_cmd_valid) begin
          m_pch = int'(i_cmd_ch); m_pt = int'(i_cmd_target); m_pi = i_cmd_instant;
          m_pend = 1;
          acc_q.push_back(ecnt);
        end
        ecnt++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [15:0] e_flat;
  logic [3:0]  e_busy;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        e_flat[4*i +: 4] = 4'(m_duty[i]);
        e_busy[i]        = (m_duty[i] != m_tgt[i]);
      end
      chk("duty_flat", int'(o_duty_flat), int'(e_flat));
      chk("busy", int'(o_busy), int'(e_busy));
      chk("sel", int'(o_sel), (ecnt / SCAN_DIV) % 4);
      chk("cmd_ready", int'(o_cmd_ready), int'(!m_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Call at a negedge; returns at the negedge just after the accept edge.
  // cmd_valid is left asserted so callers can chain commands back to back.
  task automatic send(input int ch, input int tgt, input bit inst);
    int n;
    n = 0;
    i_cmd_valid   = 1'b1;
    i_cmd_ch      = 2'(ch);
    i_cmd_target  = 4'(tgt);
    i_cmd_instant = inst;
    while (!o_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_cmd_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: cmd_ready stuck at 0, required 1");
    end
    @(negedge clk);
  endtask

  task automatic mid_cycle_reset();
    i_cmd_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_duty_flat", int'(o_duty_flat), 0);
    chk("rst_sel", int'(o_sel), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_cmd_ready", int'(o_cmd_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int vals [$];
    int stamps [$];
    int prev, mx, d1b, d2b, n;
    bit ok;
    int s [9];

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. reset mid-cycle, after some activity
    send(2, 7, 1); i_cmd_valid = 1'b0;
    send(1, 9, 0); i_cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    mid_cycle_reset();
    @(negedge clk);

    // 2. fade up ch1 to 5
    send(1, 5, 0); i_cmd_valid = 1'b0;
    prev = int'(o_duty_flat[7:4]);
    for (int c = 0; c < 60 && vals.size() < 5; c++) begin
      @(negedge clk);
      if (int'(o_duty_flat[7:4]) != prev) begin
        prev = int'(o_duty_flat[7:4]);
        vals.push_back(prev);
        stamps.push_back(ecnt);
      end
    end
    chk("fade_up_count", vals.size(), 5);
    for (int j = 0; j < vals.size(); j++) chk("fade_up_val", vals[j], j + 1);
    for (int j = 1; j < stamps.size(); j++) chk("fade_up_gap", stamps[j] - stamps[j-1], 4);
    chk("fade_up_busy1", int'(o_busy[1]), 0);
    chk("fade_up_others", int'(o_duty_flat & 16'hFF0F), 0);

    // 3. instant ch3 -> 15
    send(3, 15, 1); i_cmd_valid = 1'b0;
    chk("instant_ready_low", int'(o_cmd_ready), 0);
    @(negedge clk);
    chk("instant_ready_back", int'(o_cmd_ready), 1);
    chk("instant_duty3", int'(o_duty_flat[15:12]), 15);

    // 4. retarget ch0 mid-fade
    send(0, 12, 0); i_cmd_valid = 1'b0;
    n = 0;
    while (o_duty_flat[3:0] != 4'd6 && n < 100) begin @(negedge clk); n++; end
    chk("retarget_reach6", int'(o_duty_flat[3:0]), 6);
    send(0, 2, 0); i_cmd_valid = 1'b0;
    mx = 6; n = 0;
    while (!(o_duty_flat[3:0] == 4'd2 && !o_busy[0]) && n < 100) begin
      if (int'(o_duty_flat[3:0]) > mx) mx = int'(o_duty_flat[3:0]);
      @(negedge clk); n++;
    end
    chk("retarget_max_le7", int'(mx <= 7), 1);
    chk("retarget_final", int'(o_duty_flat[3:0]), 2);

    // 5. back-to-back with cmd_valid held
    acc_q.delete();
    send(0, 3, 1); send(1, 8, 1); send(2, 11, 1); send(3, 1, 1);
    i_cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accepts", acc_q.size(), 4);
    for (int j = 1; j < acc_q.size(); j++) chk("b2b_spacing", acc_q[j] - acc_q[j-1], 2);
    chk("b2b_duties", int'(o_duty_flat), 16'h1B83);

    // 6. APPLY coinciding with a fade tick
    send(1, 15, 0); i_cmd_valid = 1'b0;
    send(2, 10, 1); i_cmd_valid = 1'b0;
    send(2, 0, 0);  i_cmd_valid = 1'b0;
    n = 0;
    while (!(o_cmd_ready && (ecnt % TICK_DIV) == TICK_DIV - 2) && n < 20) begin
      @(negedge clk); n++;
    end
    d1b = int'(o_duty_flat[7:4]);
    d2b = int'(o_duty_flat[11:8]);
    send(2, 0, 0); i_cmd_valid = 1'b0;
    @(negedge clk);
    chk("collide_ch2_held", int'(o_duty_flat[11:8]), d2b);
    chk("collide_ch1_steps", int'(o_duty_flat[7:4]), d1b + 1);
    chk("collide_ch2_was_busy", int'(d2b != 0), 1);

    // scan select walks 0,1,2,3,0 advancing every 2 clocks
    for (int j = 0; j < 9; j++) begin s[j] = int'(o_sel); @(negedge clk); end
    ok = 1;
    for (int j = 0; j < 7; j++) if (s[j+2] != (s[j] + 1) % 4) ok = 0;
    for (int j = 0; j < 8; j++) if (s[j+1] != s[j] && s[j+1] != (s[j] + 1) % 4) ok = 0;
    chk("sel_sequence", int'(ok), 1);

    // randomized commands, one reset in the middle
    for (int it = 0; it < 150; it++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      send($urandom_range(0, 3), $urandom_range(0, 15), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) i_cmd_valid = 1'b0;
      if (it == 75) begin
        mid_cycle_reset();
        @(negedge clk);
      end
    end
    i_cmd_valid = 1'b0;
    repeat (80) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
